sdes_decrypt: RTL and testbench

Iterative S-DES decryption engine. Accepts an 8-bit ciphertext and 10-bit key over a valid/ready handshake, derives subkeys K1/K2, applies the two Feistel rounds in reverse key order (K2 then K1), and returns the 8-bit plaintext over a second valid/ready handshake. It pairs with the S-DES encryption path on the DE1-SoC datapath and uses the same S0/S1 substitution tables.

---
 rtl/sdes_pkg.sv | 68 ++++++
 rtl/sdes_decrypt_if.sv | 26 ++
 rtl/sdes_fk.sv | 23 ++
 rtl/sdes_decrypt.sv | 93 +++++++++
 tb/tb_sdes_decrypt.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sdes_pkg
// Brief   : S-DES state enum, permutations and S-box lookups shared by the
//           encrypt and decrypt paths.
// Revision: 1.0
// ============================================================================
package sdes_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYGEN = 3'd1,
        ROUND1 = 3'd2,
        ROUND2 = 3'd3,
        DONE   = 3'd4
    } state_t;

    // S-box tables packed 2 bits per entry, entry index = {row, col}
    localparam logic [31:0] c_s0_tbl = 32'hB7D8_1BB1;
    localparam logic [31:0] c_s1_tbl = 32'hC613_D2E4;

    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] x);
        return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] x);
        return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

    function automatic logic [9:0] ls1(input logic [9:0] k);
        return {k[8:5], k[9], k[3:0], k[4]};
    endfunction

    function automatic logic [9:0] ls2(input logic [9:0] k);
        return {k[7:5], k[9:8], k[2:0], k[4:3]};
    endfunction

    // row = {b1,b4}, col = {b2,b3}
    function automatic logic [1:0] s0(input logic [3:0] b);
        logic [3:0] idx;
        idx = {b[3], b[0], b[2], b[1]};
        return c_s0_tbl[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [1:0] s1(input logic [3:0] b);
        logic [3:0] idx;
        idx = {b[3], b[0], b[2], b[1]};
        return c_s1_tbl[{idx, 1'b0} +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdes_decrypt_if.sv
`default_nettype none
// ============================================================================
// Module  : sdes_decrypt_if
// Brief   : Ciphertext-in / plaintext-out valid/ready handshakes.
// Revision: 1.0
// ============================================================================
interface sdes_decrypt_if;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_cipher;
    logic [9:0] i_key;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_plain;

    modport master (
        output i_valid, i_cipher, i_key, i_ready,
        input  o_ready, o_valid, o_plain
    );

    modport slave (
        input  i_valid, i_cipher, i_key, i_ready,
        output o_ready, o_valid, o_plain
    );
endinterface
`default_nettype wire

// File: rtl/sdes_fk.sv
`default_nettype none
// ============================================================================
// Module  : sdes_fk
// Brief   : Combinational S-DES round function fK(L,R,K) -> {L ^ F(R,K), R}.
// Revision: 1.0
// ============================================================================
module sdes_fk
    import sdes_pkg::*;
(
    input  logic [7:0] i_lr,
    input  logic [7:0] i_k,
    output logic [7:0] o_lr
);

    logic [7:0] w_x;
    logic [3:0] w_p4;

    assign w_x  = ep(i_lr[3:0]) ^ i_k;
    assign w_p4 = p4({s0(w_x[7:4]), s1(w_x[3:0])});
    assign o_lr = {i_lr[7:4] ^ w_p4, i_lr[3:0]};

endmodule
`default_nettype wire

// File: rtl/sdes_decrypt.sv
`default_nettype none
// ============================================================================
// Module  : sdes_decrypt
// Brief   : Iterative S-DES decryption, 3-cycle latency, one block per 5 cycles.
// Revision: 1.0
// ============================================================================
module sdes_decrypt
    import sdes_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    sdes_decrypt_if.slave bus
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cipher;
    logic [9:0] r_key;
    logic [7:0] r_k1;
    logic [7:0] r_k2;
    logic [7:0] r_mid;
    logic [7:0] r_plain;
    logic [9:0] w_ks;
    logic [7:0] w_fk_in;
    logic [7:0] w_fk_key;
    logic [7:0] w_fk_out;

    assign w_ks = ls1(p10(r_key));

    // One fK instance shared by both rounds; decryption applies K2 first
    assign w_fk_in  = (r_state == ROUND1) ? ip(r_cipher) : r_mid;
    assign w_fk_key = (r_state == ROUND1) ? r_k2 : r_k1;

    sdes_fk u_fk (
        .i_lr (w_fk_in),
        .i_k  (w_fk_key),
        .o_lr (w_fk_out)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.i_valid) w_next = KEYGEN;
            KEYGEN:  w_next = ROUND1;
            ROUND1:  w_next = ROUND2;
            ROUND2:  w_next = DONE;
            DONE:    if (bus.i_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cipher <= 8'h00;
            r_key    <= 10'h000;
            r_k1     <= 8'h00;
            r_k2     <= 8'h00;
            r_mid    <= 8'h00;
            r_plain  <= 8'h00;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.i_valid) begin
                        r_cipher <= bus.i_cipher;
                        r_key    <= bus.i_key;
                    end
                end
                KEYGEN: begin
                    r_k1 <= p8(w_ks);
                    r_k2 <= p8(ls2(w_ks));
                end
                ROUND1:  r_mid   <= {w_fk_out[3:0], w_fk_out[7:4]};
                ROUND2:  r_plain <= ip_inv(w_fk_out);
                default: ;
            endcase
        end
    end

    // Ready is gated by reset so it reads low for the whole reset window
    assign bus.o_ready = (r_state == IDLE) && i_rst_n;
    assign bus.o_valid = (r_state == DONE);
    assign bus.o_plain = r_plain;

endmodule
`default_nettype wire

// File: tb/tb_sdes_decrypt.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdes_decrypt
// Brief   : Randomised self-checking bench for sdes_decrypt with a table-driven
//           S-DES reference model.
// Revision: 1.0
// ============================================================================
module tb_sdes_decrypt;

    logic i_clk;
    logic i_rst_n;
    sdes_decrypt_if bus ();

    sdes_decrypt dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec;
    int n_err;

    // Reference model: permutation tables exactly as listed by S-DES
    int T_P10 [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    int T_P8  [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    int T_IP  [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    int T_IPI [10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    int T_EP  [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    int T_P4  [10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
    int S0 [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    int S1 [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    function automatic logic [9:0] perm(input logic [9:0] x, input int nin,
                                        input int t [10], input int nout);
        logic [9:0] y;
        y = '0;
        for (int i = 0; i < nout; i++) y[nout-1-i] = x[nin - t[i]];
        return y;
    endfunction

    function automatic int rotl5(input int h, input int n);
        return ((h << n) | (h >> (5 - n))) & 31;
    endfunction

    function automatic void keys(input logic [9:0] key, output logic [7:0] k1,
                                 output logic [7:0] k2);
        int l, r;
        logic [9:0] p;
        p  = perm(key, 10, T_P10, 10);
        l  = rotl5(int'(p[9:5]), 1);
        r  = rotl5(int'(p[4:0]), 1);
        k1 = perm({l[4:0], r[4:0]}, 10, T_P8, 8);
        l  = rotl5(l, 2);
        r  = rotl5(r, 2);
        k2 = perm({l[4:0], r[4:0]}, 10, T_P8, 8);
    endfunction

    function automatic logic [7:0] fk(input logic [7:0] lr, input logic [7:0] k);
        logic [7:0] x;
        logic [9:0] f;
        int a, b;
        x = perm({6'b0, lr[3:0]}, 4, T_EP, 8) ^ k;
        a = S0[x[7]*2 + x[4]][x[6]*2 + x[5]];
        b = S1[x[3]*2 + x[0]][x[2]*2 + x[1]];
        f = perm(10'(a * 4 + b), 4, T_P4, 4);
        return {lr[7:4] ^ f[3:0], lr[3:0]};
    endfunction

    function automatic logic [7:0] model_dec(input logic [7:0] c, input logic [9:0] key);
        logic [7:0] k1, k2, t;
        keys(key, k1, k2);
        t = fk(perm({2'b0, c}, 8, T_IP, 8), k2);
        t = fk({t[3:0], t[7:4]}, k1);
        return perm({2'b0, t}, 8, T_IPI, 8);
    endfunction

    function automatic logic [7:0] model_enc(input logic [7:0] p, input logic [9:0] key);
        logic [7:0] k1, k2, t;
        keys(key, k1, k2);
        t = fk(perm({2'b0, p}, 8, T_IP, 8), k1);
        t = fk({t[3:0], t[7:4]}, k2);
        return perm({2'b0, t}, 8, T_IPI, 8);
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Accept one block, measure latency to o_valid, then hand it off
    task automatic run_block(input logic [7:0] c, input logic [9:0] k,
                             output logic [7:0] plain, output int lat);
        int w;
        w = 0;
        while (!bus.o_ready && w < 20) begin tick(); w++; end
        bus.i_cipher = c;
        bus.i_key    = k;
        bus.i_valid  = 1'b1;
        tick();
        bus.i_valid  = 1'b0;
        bus.i_cipher = ~c;
        bus.i_key    = ~k;
        lat = 0;
        while (!bus.o_valid && lat < 20) begin tick(); lat++; end
        plain = bus.o_plain;
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        tick(); tick();
        n_vec++;
        if (bus.o_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready_low: got %b want 0", bus.o_ready);
        end
        i_rst_n = 1'b1;
        tick(); tick();
        n_vec++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_plain !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: got ready=%b valid=%b plain=%h want 1 0 00",
                     bus.o_ready, bus.o_valid, bus.o_plain);
        end
    endtask

    task automatic test_known_vector();
        logic [7:0] p;
        int lat;
        run_block(8'b0011_1000, 10'b10_1000_0010, p, lat);
        n_vec++;
        if (dut.r_k1 !== 8'b1010_0100 || dut.r_k2 !== 8'b0100_0011) begin
            n_err++;
            $display("FAIL known_subkeys: got k1=%b k2=%b want 10100100 01000011",
                     dut.r_k1, dut.r_k2);
        end
        n_vec++;
        if (lat != 3) begin n_err++; $display("FAIL known_latency: got %0d want 3", lat); end
        n_vec++;
        if (p !== 8'b1001_0111) begin
            n_err++; $display("FAIL known_plain: got %b want 10010111", p);
        end
    endtask

    task automatic test_all_keys();
        logic [7:0] c, p;
        int lat;
        for (int k = 0; k < 1024; k++) begin
            c = 8'($urandom);
            run_block(c, 10'(k), p, lat);
            n_vec++;
            if (p !== model_dec(c, 10'(k))) begin
                n_err++;
                $display("FAIL sweep_plain key=%h c=%h: got %h want %h", k, c, p, model_dec(c, 10'(k)));
            end
            n_vec++;
            if (model_enc(p, 10'(k)) !== c) begin
                n_err++;
                $display("FAIL sweep_roundtrip key=%h: got %h want %h", k, model_enc(p, 10'(k)), c);
            end
            n_vec++;
            if (lat != 3) begin n_err++; $display("FAIL sweep_latency key=%h: got %0d want 3", k, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] c, exp;
        logic [9:0] k;
        int w;
        c = 8'($urandom); k = 10'($urandom);
        exp = model_dec(c, k);
        bus.i_cipher = c; bus.i_key = k; bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        w = 0;
        while (!bus.o_valid && w < 20) begin tick(); w++; end
        n_vec++;
        if (!bus.o_valid) begin n_err++; $display("FAIL bp_timeout: got no o_valid want 1"); end
        for (int i = 0; i < 10; i++) begin
            bus.i_valid  = ~bus.i_valid;
            bus.i_cipher = 8'($urandom);
            bus.i_key    = 10'($urandom);
            tick();
            n_vec++;
            if (bus.o_valid !== 1'b1 || bus.o_plain !== exp || bus.o_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cyc=%0d: got valid=%b plain=%h ready=%b want 1 %h 0",
                         i, bus.o_valid, bus.o_plain, bus.o_ready, exp);
            end
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0 1", bus.o_valid, bus.o_ready);
        end
        for (int i = 0; i < 6; i++) tick();
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_no_ghost: got valid=%b ready=%b want 0 1", bus.o_valid, bus.o_ready);
        end
    endtask

    task automatic test_reset_midflight();
        logic [7:0] c, p;
        logic [9:0] k;
        int lat;
        // Leave a nonzero plaintext in the output register first
        run_block(8'b0011_1000, 10'b10_1000_0010, p, lat);
        c = 8'($urandom); k = 10'($urandom);
        bus.i_cipher = c; bus.i_key = k; bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        tick();
        i_rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_plain !== 8'h00 || bus.o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_outputs: got valid=%b plain=%h ready=%b want 0 00 0",
                     bus.o_valid, bus.o_plain, bus.o_ready);
        end
        tick(); tick();
        i_rst_n = 1'b1;
        #1;
        n_vec++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_release: got ready=%b valid=%b want 1 0", bus.o_ready, bus.o_valid);
        end
        tick();
        c = 8'($urandom); k = 10'($urandom);
        run_block(c, k, p, lat);
        n_vec++;
        if (p !== model_dec(c, k) || lat != 3) begin
            n_err++;
            $display("FAIL midreset_fresh: got plain=%h lat=%0d want %h 3", p, lat, model_dec(c, k));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] exp;
        logic acc, hs;
        int sent, got, last;
        sent = 0; got = 0; last = -1;
        bus.i_key    = 10'($urandom);
        bus.i_cipher = 8'($urandom);
        bus.i_valid  = 1'b1;
        bus.i_ready  = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            acc = bus.o_ready && bus.i_valid;
            hs  = bus.o_valid && bus.i_ready;
            if (acc) q.push_back(model_dec(bus.i_cipher, bus.i_key));
            if (hs) begin
                exp = (q.size() > 0) ? q.pop_front() : ~bus.o_plain;
                n_vec++;
                if (bus.o_plain !== exp) begin
                    n_err++; $display("FAIL b2b_data #%0d: got %h want %h", got, bus.o_plain, exp);
                end
                if (last >= 0) begin
                    n_vec++;
                    if (cyc - last != 5) begin
                        n_err++; $display("FAIL b2b_spacing #%0d: got %0d want 5", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            tick();
            if (acc) begin
                sent++;
                if (sent >= 8) bus.i_valid = 1'b0;
                bus.i_cipher = 8'($urandom);
            end
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        n_vec++;
        if (got != 8 || q.size() != 0) begin
            n_err++; $display("FAIL b2b_count: got %0d outputs, %0d pending want 8 0", got, q.size());
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.i_valid  = 1'b0;
        bus.i_ready  = 1'b0;
        bus.i_cipher = 8'h00;
        bus.i_key    = 10'h000;
        i_rst_n      = 1'b0;
        test_reset();
        test_known_vector();
        test_all_keys();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
